// File: rtl/countdown_timer.sv
// MM:SS countdown timer driven by a shared once-per-second strobe.
// Commands are single-cycle strobes and need no handshake. state exposes the FSM directly.
module countdown_timer #(
    parameter int MAX_MIN     = 99,
    parameter int ALARM_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [7:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] state,
    output logic       running,
    output logic       expired,
    output logic       alarm
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        PAUSED = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam logic [7:0] MAX_MIN_L  = 8'(MAX_MIN);
    localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

    state_t     st;
    logic [7:0] alarm_cnt;
    logic       any_cmd;
    logic       nonzero;

    // Any command strobe swallows a coincident tick, even one the current state ignores.
    assign any_cmd = clear | load | start | pause;
    assign nonzero = (minutes != 8'd0) || (seconds != 6'd0);
    assign state   = st;
    assign running = (st == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= IDLE;
            minutes   <= 8'd0;
            seconds   <= 6'd0;
            expired   <= 1'b0;
            alarm     <= 1'b0;
            alarm_cnt <= 8'd0;
        end else begin
            expired <= 1'b0;
            if (clear) begin
                st        <= IDLE;
                minutes   <= 8'd0;
                seconds   <= 6'd0;
                alarm     <= 1'b0;
                alarm_cnt <= 8'd0;
            end else if (load && st != RUN) begin
                st        <= IDLE;
                minutes   <= (load_min > MAX_MIN_L) ? MAX_MIN_L : load_min;
                seconds   <= (load_sec > 6'd59) ? 6'd59 : load_sec;
                alarm     <= 1'b0;
                alarm_cnt <= 8'd0;
            end else if (start && (st == IDLE || st == PAUSED) && nonzero) begin
                st <= RUN;
            end else if (pause && st == RUN) begin
                st <= PAUSED;
            end else if (!any_cmd && sec_tick) begin
                case (st)
                    RUN: begin
                        if (seconds != 6'd0) begin
                            seconds <= seconds - 6'd1;
                            if (seconds == 6'd1 && minutes == 8'd0) begin
                                st        <= DONE;
                                expired   <= 1'b1;
                                alarm     <= 1'b1;
                                alarm_cnt <= 8'd0;
                            end
                        end else begin
                            minutes <= minutes - 8'd1;
                            seconds <= 6'd59;
                        end
                    end
                    DONE: begin
                        // Ticks are counted only after the entry edge; the last one drops alarm.
                        if (alarm) begin
                            if (alarm_cnt == ALARM_LAST) begin
                                alarm <= 1'b0;
                            end else begin
                                alarm_cnt <= alarm_cnt + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
